// File: rtl/nv_nvdla_attn_pkg.sv
// nv_nvdla_attn_pkg: shared MCIF widths, request struct and responder FSM states
package nv_nvdla_attn_pkg;
    localparam int MCIF_LINE_BYTES = 64;
    localparam int RD_REQ_PD_W = 79;
    localparam int RD_RSP_PD_W = 514;

    typedef struct packed {
        logic [63:0] addr;
        logic [14:0] size;
    } rd_req_t;

    typedef enum logic [1:0] {IDLE, WAIT, STREAM} rsp_state_e;
endpackage

// File: rtl/nv_nvdla_attn_rd_req_fifo.sv
// nv_nvdla_attn_rd_req_fifo: sync request FIFO with registered full/empty flags
module nv_nvdla_attn_rd_req_fifo
    import nv_nvdla_attn_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  rd_req_t din,
    output rd_req_t dout,
    output logic    full,
    output logic    empty
);
    rd_req_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt, cnt_nxt;
    logic do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign cnt_nxt = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign dout = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
            full <= 1'b0;
            empty <= 1'b1;
        end else begin
            wp <= wp + AW'(do_push);
            rp <= rp + AW'(do_pop);
            cnt <= cnt_nxt;
            full <= cnt_nxt == (AW+1)'(DEPTH);
            empty <= cnt_nxt == '0;
        end
    end
endmodule

// File: rtl/nv_nvdla_attn_mcif_rd_responder.sv
// nv_nvdla_attn_mcif_rd_responder: memory-side MCIF read responder streaming
// 64-byte lines from a preloadable line store after a fixed latency.
module nv_nvdla_attn_mcif_rd_responder
    import nv_nvdla_attn_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int LATENCY = 3,
    parameter int REQ_FIFO = 4,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rst,
    input  logic                   attn2mcif_rd_req_valid,
    output logic                   attn2mcif_rd_req_ready,
    input  logic [RD_REQ_PD_W-1:0] attn2mcif_rd_req_pd,
    output logic                   mcif2attn_rd_rsp_valid,
    input  logic                   mcif2attn_rd_rsp_ready,
    output logic [RD_RSP_PD_W-1:0] mcif2attn_rd_rsp_pd,
    input  logic                   preload_we,
    input  logic [IW-1:0]          preload_idx,
    input  logic [511:0]           preload_data,
    output logic                   err_oob,
    output logic [31:0]            beats_sent
);
    localparam int LW = $clog2(LATENCY) + 1;

    rd_req_t req_in, head;
    logic fifo_full, fifo_empty, push, pop;
    rsp_state_e state, state_nxt;
    logic [64:0] diff;
    logic [58:0] cur_line, rd_line;
    logic [14:0] cur_beats, beat_cnt;
    logic [LW-1:0] lat_cnt;
    logic [511:0] store [DEPTH];
    logic [511:0] rd_data;
    logic beat_oob, last, hs, first, load, unused_ok;

    assign req_in = attn2mcif_rd_req_pd;
    assign attn2mcif_rd_req_ready = !nvdla_core_rst && !fifo_full;
    assign push = attn2mcif_rd_req_valid && attn2mcif_rd_req_ready;
    assign pop = state == IDLE && !fifo_empty;
    // 65-bit difference keeps the sign so addresses below the base read as negative lines
    assign diff = {1'b0, head.addr} - {1'b0, BASE_ADDR};
    assign unused_ok = ^diff[5:0];

    nv_nvdla_attn_rd_req_fifo #(.DEPTH(REQ_FIFO)) u_fifo (
        .clk   (nvdla_core_clk),
        .rst   (nvdla_core_rst),
        .push  (push),
        .pop   (pop),
        .din   (req_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        rd_line = cur_line + {58'd0, state == STREAM};
        beat_oob = rd_line[58] || rd_line[57:0] >= 58'(DEPTH);
        rd_data = store[rd_line[IW-1:0]];
        hs = state == STREAM && mcif2attn_rd_rsp_ready;
        last = beat_cnt == cur_beats;
        first = state == WAIT && lat_cnt == '0;
        load = first || (hs && !last);
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = fifo_empty ? IDLE : WAIT;
            WAIT:    state_nxt = first ? STREAM : WAIT;
            STREAM:  state_nxt = hs && last ? IDLE : STREAM;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (preload_we) store[preload_idx] <= preload_data;
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state <= IDLE;
            mcif2attn_rd_rsp_valid <= 1'b0;
            mcif2attn_rd_rsp_pd <= '0;
            err_oob <= 1'b0;
            beats_sent <= '0;
            cur_line <= '0;
            cur_beats <= '0;
            beat_cnt <= '0;
            lat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                cur_line <= diff[64:6];
                cur_beats <= head.size;
                beat_cnt <= '0;
                lat_cnt <= LW'(LATENCY - 1);
            end
            if (state == WAIT) lat_cnt <= lat_cnt - LW'(1);
            if (load) begin
                mcif2attn_rd_rsp_pd <= {2'b11, rd_data & {512{!beat_oob}}};
                err_oob <= err_oob | beat_oob;
            end
            if (first) mcif2attn_rd_rsp_valid <= 1'b1;
            if (hs) begin
                beats_sent <= beats_sent + 32'd1;
                if (last) mcif2attn_rd_rsp_valid <= 1'b0;
                else begin
                    beat_cnt <= beat_cnt + 15'd1;
                    cur_line <= cur_line + 59'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_nv_nvdla_attn_mcif_rd_responder.sv
// tb_nv_nvdla_attn_mcif_rd_responder: directed self-checking bench for the MCIF read responder
module tb_nv_nvdla_attn_mcif_rd_responder;
    import nv_nvdla_attn_pkg::*;
    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

    logic nvdla_core_clk = 1'b0;
    logic nvdla_core_rst = 1'b1;
    logic attn2mcif_rd_req_valid = 1'b0;
    logic attn2mcif_rd_req_ready;
    logic [78:0] attn2mcif_rd_req_pd = '0;
    logic mcif2attn_rd_rsp_valid;
    logic mcif2attn_rd_rsp_ready = 1'b0;
    logic [513:0] mcif2attn_rd_rsp_pd;
    logic preload_we = 1'b0;
    logic [9:0] preload_idx = '0;
    logic [511:0] preload_data = '0;
    logic err_oob;
    logic [31:0] beats_sent;
    int total = 0;
    int bad = 0;

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    nv_nvdla_attn_mcif_rd_responder dut (
        .nvdla_core_clk         (nvdla_core_clk),
        .nvdla_core_rst         (nvdla_core_rst),
        .attn2mcif_rd_req_valid (attn2mcif_rd_req_valid),
        .attn2mcif_rd_req_ready (attn2mcif_rd_req_ready),
        .attn2mcif_rd_req_pd    (attn2mcif_rd_req_pd),
        .mcif2attn_rd_rsp_valid (mcif2attn_rd_rsp_valid),
        .mcif2attn_rd_rsp_ready (mcif2attn_rd_rsp_ready),
        .mcif2attn_rd_rsp_pd    (mcif2attn_rd_rsp_pd),
        .preload_we             (preload_we),
        .preload_idx            (preload_idx),
        .preload_data           (preload_data),
        .err_oob                (err_oob),
        .beats_sent             (beats_sent)
    );

    task automatic step;
        @(posedge nvdla_core_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [513:0] obs, input logic [513:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [511:0] d);
        preload_we = 1'b1;
        preload_idx = 10'(idx);
        preload_data = d;
        step;
        preload_we = 1'b0;
    endtask

    task automatic send(input int line, input logic [14:0] sz, input string tag);
        attn2mcif_rd_req_valid = 1'b1;
        attn2mcif_rd_req_pd = {BASE + 64'(line) * 64'd64, sz};
        for (int i = 0; i < 40 && !attn2mcif_rd_req_ready; i++) step;
        chk({tag, "_req_rdy"}, 514'(attn2mcif_rd_req_ready), 514'(1));
        step;
        attn2mcif_rd_req_valid = 1'b0;
    endtask

    task automatic recv(input logic [511:0] exp, input int stalls, input string tag);
        logic [513:0] held;
        mcif2attn_rd_rsp_ready = 1'b0;
        for (int i = 0; i < 40 && !mcif2attn_rd_rsp_valid; i++) step;
        chk({tag, "_vld"}, 514'(mcif2attn_rd_rsp_valid), 514'(1));
        held = mcif2attn_rd_rsp_pd;
        for (int i = 0; i < stalls; i++) begin
            step;
            chk({tag, "_hold"}, mcif2attn_rd_rsp_pd, held);
        end
        chk({tag, "_pd"}, mcif2attn_rd_rsp_pd, {2'b11, exp});
        mcif2attn_rd_rsp_ready = 1'b1;
        step;
        mcif2attn_rd_rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        step;
        step;
        chk("rst_vld", 514'(mcif2attn_rd_rsp_valid), 514'(0));
        chk("rst_pd", mcif2attn_rd_rsp_pd, 514'(0));
        chk("rst_req_rdy", 514'(attn2mcif_rd_req_ready), 514'(0));
        chk("rst_err", 514'(err_oob), 514'(0));
        chk("rst_beats", 514'(beats_sent), 514'(0));
        nvdla_core_rst = 1'b0;
        #1;
        chk("post_rst_req_rdy", 514'(attn2mcif_rd_req_ready), 514'(1));

        // single beat with latency check: accept at T, valid after T+4
        preload(0, {64{8'hA5}});
        mcif2attn_rd_rsp_ready = 1'b1;
        send(0, 15'd0, "t1");
        chk("t1_lat0", 514'(mcif2attn_rd_rsp_valid), 514'(0));
        step;
        chk("t1_lat1", 514'(mcif2attn_rd_rsp_valid), 514'(0));
        step;
        chk("t1_lat2", 514'(mcif2attn_rd_rsp_valid), 514'(0));
        step;
        chk("t1_lat3", 514'(mcif2attn_rd_rsp_valid), 514'(0));
        step;
        chk("t1_vld", 514'(mcif2attn_rd_rsp_valid), 514'(1));
        chk("t1_pd", mcif2attn_rd_rsp_pd, {2'b11, {64{8'hA5}}});
        step;
        chk("t1_vld_drop", 514'(mcif2attn_rd_rsp_valid), 514'(0));
        chk("t1_beats", 514'(beats_sent), 514'(1));
        mcif2attn_rd_rsp_ready = 1'b0;

        // burst of 4 with a two-cycle stall on the second beat
        for (int i = 4; i < 8; i++) preload(i, 512'(i));
        send(4, 15'd3, "t2");
        recv(512'(4), 0, "t2_b0");
        recv(512'(5), 2, "t2_b1");
        recv(512'(6), 0, "t2_b2");
        recv(512'(7), 0, "t2_b3");
        chk("t2_vld_end", 514'(mcif2attn_rd_rsp_valid), 514'(0));
        chk("t2_beats", 514'(beats_sent), 514'(5));

        // FIFO full: one request in service plus four queued
        for (int i = 10; i < 15; i++) preload(i, 512'(100 + i));
        for (int i = 10; i < 15; i++) send(i, 15'd0, "t3");
        chk("t3_full0", 514'(attn2mcif_rd_req_ready), 514'(0));
        step;
        step;
        chk("t3_full1", 514'(attn2mcif_rd_req_ready), 514'(0));
        for (int i = 10; i < 15; i++) recv(512'(100 + i), 0, "t3_rsp");
        chk("t3_req_rdy_back", 514'(attn2mcif_rd_req_ready), 514'(1));
        chk("t3_beats", 514'(beats_sent), 514'(10));
        chk("t3_err", 514'(err_oob), 514'(0));

        // last line then one beat past the end of the store
        preload(1023, 512'hDEAD_BEEF);
        send(1023, 15'd1, "t4");
        recv(512'hDEAD_BEEF, 0, "t4_b0");
        recv(512'(0), 0, "t4_b1");
        chk("t4_err", 514'(err_oob), 514'(1));
        step;
        step;
        chk("t4_err_sticky", 514'(err_oob), 514'(1));
        chk("t4_beats", 514'(beats_sent), 514'(12));

        // reset while beat 2 of an 8-beat burst is presented
        for (int i = 20; i < 28; i++) preload(i, 512'(200 + i));
        send(20, 15'd7, "t5");
        recv(512'(220), 0, "t5_b0");
        recv(512'(221), 0, "t5_b1");
        chk("t5_b2_vld", 514'(mcif2attn_rd_rsp_valid), 514'(1));
        chk("t5_b2_pd", mcif2attn_rd_rsp_pd, {2'b11, 512'(222)});
        nvdla_core_rst = 1'b1;
        mcif2attn_rd_rsp_ready = 1'b1;
        step;
        chk("t5_rst_req_rdy", 514'(attn2mcif_rd_req_ready), 514'(0));
        nvdla_core_rst = 1'b0;
        chk("t5_vld", 514'(mcif2attn_rd_rsp_valid), 514'(0));
        chk("t5_beats", 514'(beats_sent), 514'(0));
        chk("t5_err", 514'(err_oob), 514'(0));
        chk("t5_pd", mcif2attn_rd_rsp_pd, 514'(0));
        for (int i = 0; i < 8; i++) begin
            step;
            chk("t5_quiet", 514'(mcif2attn_rd_rsp_valid), 514'(0));
        end
        mcif2attn_rd_rsp_ready = 1'b0;
        send(20, 15'd0, "t5_again");
        recv(512'(220), 0, "t5_again");
        chk("t5_beats_after", 514'(beats_sent), 514'(1));

        // preload write on the same edge the line is loaded into the response
        preload(30, 512'h11);
        mcif2attn_rd_rsp_ready = 1'b1;
        send(30, 15'd0, "t6");
        step;
        step;
        step;
        preload_we = 1'b1;
        preload_idx = 10'd30;
        preload_data = 512'h22;
        step;
        preload_we = 1'b0;
        chk("t6_vld", 514'(mcif2attn_rd_rsp_valid), 514'(1));
        chk("t6_old", mcif2attn_rd_rsp_pd, {2'b11, 512'h11});
        step;
        chk("t6_vld_drop", 514'(mcif2attn_rd_rsp_valid), 514'(0));
        mcif2attn_rd_rsp_ready = 1'b0;
        send(30, 15'd0, "t6_new");
        recv(512'h22, 0, "t6_new");
        chk("t6_beats", 514'(beats_sent), 514'(3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
